// File: rtl/alu_cmd_driver_if.sv
// Command/response channel bundle for alu_cmd_driver.
// The master side (a sequencer or datapath controller) issues commands and
// consumes responses. The slave side (the driver) accepts commands and
// produces responses.
interface alu_cmd_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [4:0]  cmd_shamt;
    logic [3:0]  cmd_funct;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_funct;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_shamt, cmd_funct, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_funct
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_shamt, cmd_funct, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_funct
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Issuer/collector for a fixed-latency ALU.
// A command is accepted only in IDLE, and its operands are registered onto the
// ALU bus. The driver waits ALU_LAT edges, captures the ALU result and presents
// it on the response channel until it is taken. Only one operation is in
// flight at a time. The operand bus holds its value until the next accept, so
// the ALU always sees stable inputs.
module alu_cmd_driver #(
    parameter int ALU_LAT = 1,   // edges from stable operands to valid out, 0..15
    parameter int CNT_W   = 16   // width of completed-operation counter
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_driver_if.slave   bus,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [4:0]        alu_shamt,
    output logic [3:0]        alu_funct,
    input  logic [31:0]       alu_out,
    output logic [CNT_W-1:0]  ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [31:0]       a_reg, a_next;
    logic [31:0]       b_reg, b_next;
    logic [4:0]        shamt_reg, shamt_next;
    logic [3:0]        funct_reg, funct_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_data_reg, rsp_data_next;
    logic [3:0]        rsp_funct_reg, rsp_funct_next;
    logic [CNT_W-1:0]  ops_reg, ops_next;
    logic              cmd_accept;

    // Ready comes straight from the state so the source sees it in the same cycle.
    assign bus.cmd_ready = (state_reg == IDLE) && !rst;
    assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;

    assign alu_a         = a_reg;
    assign alu_b         = b_reg;
    assign alu_shamt     = shamt_reg;
    assign alu_funct     = funct_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_funct = rsp_funct_reg;
    assign ops_done      = ops_reg;

    // State and datapath registers. Reset aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            shamt_reg     <= '0;
            funct_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_funct_reg <= '0;
            ops_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            shamt_reg     <= shamt_next;
            funct_reg     <= funct_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_funct_reg <= rsp_funct_next;
            ops_reg       <= ops_next;
        end
    end

    // Next-state and register-update decode. Every register holds by default.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        shamt_next     = shamt_reg;
        funct_next     = funct_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_funct_next = rsp_funct_reg;
        ops_next       = ops_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_accept) begin
                    a_next     = bus.cmd_a;
                    b_next     = bus.cmd_b;
                    shamt_next = bus.cmd_shamt;
                    funct_next = bus.cmd_funct;
                    cnt_next   = LAT_INIT;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    // The operands have been stable for ALU_LAT edges, so alu_out is valid.
                    rsp_data_next  = alu_out;
                    rsp_funct_next = funct_reg;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_reg && bus.rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    ops_next       = ops_reg + CNT_W'(1);
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
